cic_sample_formatter: RTL



---
 rtl/cic_pkg.sv | 40 ++++
 rtl/cic_sample_formatter_sync_fifo.sv | 77 +++++++
 rtl/cic_sample_formatter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared constants, FSM encoding and the CIC code-to-sample conversion rule
// used by the formatter RTL and any reference model.
package cic_pkg;

    localparam int unsigned CIC_ORDER          = 3;
    localparam int unsigned DEFAULT_DECIMATION = 256;

    typedef logic [1:0] cic_state_t;

    localparam cic_state_t ST_IDLE   = 2'd0;
    localparam cic_state_t ST_SETTLE = 2'd1;
    localparam cic_state_t ST_RUN    = 2'd2;

    typedef struct packed {
        logic        clip;
        logic [31:0] value;
    } cic_conv_t;

    function automatic int unsigned cic_numbits(input int unsigned decimation);
        return CIC_ORDER * $clog2(decimation) + 1;
    endfunction

    // Remove the mid-scale offset, drop LSBs toward -inf, clamp the positive
    // end. Computed at 64 bits so codes >= 2^(numbits-1) never wrap negative.
    function automatic cic_conv_t cic_to_signed(input logic [63:0]  code,
                                                input int unsigned numbits,
                                                input int unsigned out_width);
        logic signed [63:0] s;
        logic signed [63:0] q;
        logic signed [63:0] q_max;
        cic_conv_t          r;
        s       = $signed(code) - (64'sd1 <<< (numbits - 2));
        q       = s >>> (numbits - 1 - out_width);
        q_max   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        r.clip  = (q > q_max);
        r.value = r.clip ? 32'(q_max) : 32'(q);
        return r;
    endfunction

endpackage

// File: rtl/cic_sample_formatter_sync_fifo.sv
// First-word-fall-through FIFO with a registered head word; the head register
// holds its last value while the FIFO is empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   head_ptr_c;
    logic [LEVEL_W-1:0] level_nxt_c;
    logic               push_c;
    logic               pop_c;

    // A push while full is only taken when a pop frees the slot this cycle.
    assign pop_c      = rd_en && !empty;
    assign push_c     = wr_en && (!full || pop_c);
    assign head_ptr_c = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        level_nxt_c = level;
        if (push_c && !pop_c) begin
            level_nxt_c = level + LEVEL_W'(1);
        end else if (!push_c && pop_c) begin
            level_nxt_c = level - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head register bypasses the write data when the new head is being written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level    <= level_nxt_c;
            full     <= (level_nxt_c == LEVEL_W'(DEPTH));
            empty    <= (level_nxt_c == '0);
            rd_valid <= (level_nxt_c != '0);
            if (level_nxt_c != '0) begin
                rd_data <= (push_c && (wr_ptr == head_ptr_c)) ? wr_data : mem[head_ptr_c];
            end
        end
    end

endmodule

// File: rtl/cic_sample_formatter.sv
// CIC output formatter: drops the start-up transient, converts the unsigned
// CIC code to a saturated signed sample and buffers it for the consumer.
module cic_sample_formatter
    import cic_pkg::*;
#(
    parameter int unsigned DECIMATION_FACTOR = DEFAULT_DECIMATION,
    parameter int unsigned CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
    parameter int unsigned NUMBITS           = 3 * CLOCK_WIDTH + 1,
    parameter int unsigned OUT_WIDTH         = 16,
    parameter int unsigned FIFO_DEPTH        = 8,
    parameter int unsigned DISCARD_COUNT     = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUMBITS-1:0]            cic_data,
    input  logic                          cic_stb,
    output logic [OUT_WIDTH-1:0]          m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          clipped,
    input  logic                          flag_clr
);

    localparam int unsigned CNT_W = (DISCARD_COUNT > 0) ? $clog2(DISCARD_COUNT + 1) : 1;

    cic_state_t       state;
    cic_state_t       state_nxt;
    logic [CNT_W-1:0] discard_cnt;
    logic [CNT_W-1:0] discard_cnt_nxt;
    logic             capture_c;

    cic_conv_t        conv_c;
    logic             conv_unused;
    logic             s1_valid;
    logic [OUT_WIDTH-1:0] s1_data;

    logic             fifo_full;
    logic             fifo_empty_unused;
    logic             pop_c;
    logic             overflow_set_c;
    logic             clip_set_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            discard_cnt <= '0;
        end else begin
            state       <= state_nxt;
            discard_cnt <= discard_cnt_nxt;
        end
    end

    // Enable low wins over everything, so a strobe coincident with it is lost.
    always_comb begin
        state_nxt       = state;
        discard_cnt_nxt = discard_cnt;
        capture_c       = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (DISCARD_COUNT == 0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        state_nxt       = ST_SETTLE;
                        discard_cnt_nxt = CNT_W'(DISCARD_COUNT);
                    end
                end
                ST_SETTLE: begin
                    if (cic_stb) begin
                        discard_cnt_nxt = discard_cnt - CNT_W'(1);
                        if (discard_cnt <= CNT_W'(1)) begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    capture_c = cic_stb;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign conv_c      = cic_to_signed(64'(cic_data), NUMBITS, OUT_WIDTH);
    assign conv_unused = &{1'b0, conv_c.value[31:OUT_WIDTH]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= capture_c;
            if (capture_c) begin
                s1_data <= conv_c.value[OUT_WIDTH-1:0];
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (s1_valid),
        .wr_data  (s1_data),
        .rd_en    (m_ready),
        .rd_data  (m_data),
        .rd_valid (m_valid),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty_unused)
    );

    assign pop_c          = m_valid && m_ready;
    assign overflow_set_c = s1_valid && fifo_full && !pop_c;
    assign clip_set_c     = capture_c && conv_c.clip;

    // Sticky flags: a set event in the clearing cycle takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            clipped  <= 1'b0;
        end else begin
            if (overflow_set_c) begin
                overflow <= 1'b1;
            end else if (flag_clr) begin
                overflow <= 1'b0;
            end
            if (clip_set_c) begin
                clipped <= 1'b1;
            end else if (flag_clr) begin
                clipped <= 1'b0;
            end
        end
    end

endmodule
